mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multi-cycle CPU datapath (port 0, driven by the control FSM's MemRead/MemWrite/IorD path) and the boot/program loader (port 1).
- Serialises accesses, drives the memory's one-cycle enable strobe and counts the fixed memory latency.
- Returns registered read data plus a one-cycle ack, and raises a stall that freezes the CPU control FSM while its access is outstanding.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- ld_req  in  1  loader request; same rules as cpu_req.
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_rdata  out  DW  loader read data, valid with ld_ack.
- ld_ack  out  1  loader completion pulse.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en.
- gnt  out  2  one-hot grant; bit0 = CPU, bit1 = loader.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (nrst).
- Reset values: all outputs 0, state IDLE, latency counter 0, data registers 0, last_grant = 1.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any request is present: select a winner, register its we/addr/wdata into mem_we/mem_addr/mem_wdata, set gnt, load counter = LAT, go to ACCESS.
  - Otherwise remain in IDLE with gnt = 0.
- ACCESS: mem_en = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0 (LAT cycles after ACCESS), capture mem_rdata into the granted port's rdata register and go to RESP.
  - Writes take the same path; captured data for a write is don't-care, but the rdata register of a write port is not updated.
- RESP: pulse the granted port's ack for one cycle, then go to IDLE; gnt clears on entry to IDLE.
- Latency: request sampled in IDLE at cycle T gives ACCESS at T+1 and ack at T+LAT+2. Back-to-back throughput is one access per LAT+3 cycles.
- Register stability:
  - mem_addr, mem_we and mem_wdata are stable from ACCESS through RESP.
  - The rdata registers hold their value until the next ack to the same port.
- Requester rules:
  - A requester keeps req high with stable inputs until its ack.
  - Req still high in the cycle after ack counts as a new request.
  - If req drops mid-transaction, the transaction still completes and ack still pulses; the requester ignores it.
- Simultaneous requests: resolved in IDLE only, per the arbitration mode below. The loser waits; its cpu_stall stays high.
- Reset mid-operation:
  - Asynchronous abort: mem_en and acks drop immediately and no ack is issued.
  - An in-flight write may or may not have landed in memory; that is the memory's responsibility.
- LAT outside 1..15 is a configuration error; behaviour is not guaranteed.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a tie in IDLE, grant the port not recorded in last_grant.
  - last_grant updates on every grant.
  - After reset (last_grant = 1), the CPU wins the first tie.
- Undefined: fixed priority; the CPU (port 0) always wins a tie. The last_grant register is not built.

Test Plan:
- LAT=1; CPU read, addr 0x10, memory holds 0xDEADBEEF there; cpu_req rises at cycle 0 -> mem_en high at cycle 1 only, cpu_ack at cycle 3, cpu_rdata = 0xDEADBEEF, cpu_stall high for cycles 0-2.
- LAT=3; loader write, addr 0x40, data 0x12345678, followed by a CPU read of 0x40 -> ld_ack at cycle 5; the CPU read returns 0x12345678; ld_rdata is unchanged.
- Both req high at cycle 0 continuously, MEM_ARB_RR_EN undefined -> grants CPU, CPU, CPU…; ld_ack never pulses while cpu_req is held.
- Same stimulus with MEM_ARB_RR_EN defined -> grant order CPU, LD, CPU, LD; each ack spaced LAT+3 cycles apart.
- nrst pulsed low during WAIT of a CPU read -> all outputs 0 asynchronously, no cpu_ack; after release, a held cpu_req restarts with ACCESS one cycle after the first IDLE cycle.
- cpu_req dropped in ACCESS -> cpu_ack still pulses at T+LAT+2; busy returns low in the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-port arbiter for the unified instruction/data memory.
//                Port 0 is the CPU datapath, port 1 the boot/program loader.
//                Serialises accesses, issues the one-cycle mem_en strobe,
//                counts the fixed read latency, and returns registered read
//                data with a one-cycle ack per port.
//  Options     : MEM_ARB_RR_EN - when defined, simultaneous requests are
//                resolved round-robin.  When undefined, the CPU always wins
//                a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          nrst,
  // CPU port (port 0)
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  // Loader port (port 1)
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  // Memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // Status
  output logic [1:0]    gnt,
  output logic          busy
);

  // Latency counter is wide enough for the full legal LAT range 1..15.
  localparam int         c_CW  = 4;
  localparam [c_CW-1:0]  c_LAT = c_CW'(LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [1:0]      r_gnt;
  logic [1:0]      w_gnt_nxt;
  logic            r_mem_we;
  logic            w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr;
  logic [AW-1:0]   w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   w_mem_wdata_nxt;
  logic [DW-1:0]   r_cpu_rdata;
  logic [DW-1:0]   w_cpu_rdata_nxt;
  logic [DW-1:0]   r_ld_rdata;
  logic [DW-1:0]   w_ld_rdata_nxt;

  logic            w_any_req;
  logic            w_sel_ld;   // 1 = loader wins the IDLE arbitration

  assign w_any_req = cpu_req | ld_req;

`ifdef MEM_ARB_RR_EN
  // last_grant: 0 = CPU was granted last, 1 = loader was granted last.
  // Reset value 1 makes the CPU win the first tie after reset.
  logic r_last_grant;
  logic w_last_grant_nxt;

  // Round-robin winner: loader takes a tie only when the CPU went last.
  always_comb begin
    w_sel_ld = ld_req & (~cpu_req | ~r_last_grant);
  end

  // Remember which port received the most recent grant.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_grant <= 1'b1;
    end else begin
      r_last_grant <= w_last_grant_nxt;
    end
  end
`else
  // Fixed priority winner: the CPU always takes a tie.
  always_comb begin
    w_sel_ld = ld_req & ~cpu_req;
  end
`endif

  // State, latency counter, captured access and returned data registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gnt       <= 2'b00;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_ld_rdata  <= w_ld_rdata_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, strobe in ACCESS, count in WAIT,
  // acknowledge in RESP.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_gnt_nxt       = r_gnt;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_ld_rdata_nxt  = r_ld_rdata;
`ifdef MEM_ARB_RR_EN
    w_last_grant_nxt = r_last_grant;
`endif

    case (r_state)
      IDLE: begin
        w_gnt_nxt = 2'b00;
        if (w_any_req) begin
          // Latch the winner's access so the memory side stays stable
          // even if the requester changes its inputs afterwards.
          w_mem_we_nxt    = w_sel_ld ? ld_we    : cpu_we;
          w_mem_addr_nxt  = w_sel_ld ? ld_addr  : cpu_addr;
          w_mem_wdata_nxt = w_sel_ld ? ld_wdata : cpu_wdata;
          w_gnt_nxt       = w_sel_ld ? 2'b10 : 2'b01;
          w_cnt_nxt       = c_LAT;
          w_state_nxt     = ACCESS;
`ifdef MEM_ARB_RR_EN
          w_last_grant_nxt = w_sel_ld;
`endif
        end
      end

      ACCESS: begin
        w_state_nxt = WAIT;
      end

      WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        // The counter leaves 1 on the cycle mem_rdata is valid, so the
        // capture lands exactly LAT cycles after the mem_en cycle.
        if (r_cnt <= 1) begin
          w_cnt_nxt = '0;
          if (!r_mem_we) begin
            if (r_gnt[0]) begin
              w_cpu_rdata_nxt = mem_rdata;
            end
            if (r_gnt[1]) begin
              w_ld_rdata_nxt = mem_rdata;
            end
          end
          w_state_nxt = RESP;
        end
      end

      RESP: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = IDLE;
      end

      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Strobes and acks decode straight from state so an asynchronous reset
  // removes them immediately.
  assign mem_en    = (r_state == ACCESS);
  assign cpu_ack   = (r_state == RESP) & r_gnt[0];
  assign ld_ack    = (r_state == RESP) & r_gnt[1];
  assign busy      = (r_state != IDLE);
  assign gnt       = r_gnt;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign ld_rdata  = r_ld_rdata;

  // Stall is held low while reset is asserted so every output reads zero.
  assign cpu_stall = nrst & cpu_req & ~cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Instance A uses
//                LAT=1, instance B uses LAT=3 and also runs a randomized
//                phase against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // ---------------- instance A (LAT=1) ----------------
  logic        a_cpu_req   = 1'b0;
  logic        a_cpu_we    = 1'b0;
  logic [31:0] a_cpu_addr  = '0;
  logic [31:0] a_cpu_wdata = '0;
  logic        a_ld_req    = 1'b0;
  logic        a_ld_we     = 1'b0;
  logic [31:0] a_ld_addr   = '0;
  logic [31:0] a_ld_wdata  = '0;
  logic [31:0] a_cpu_rdata, a_ld_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_cpu_ack, a_cpu_stall, a_ld_ack, a_mem_en, a_mem_we, a_busy;
  logic [1:0]  a_gnt;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT_A)) u_dut_a (
    .clk(clk), .nrst(nrst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
    .cpu_stall(a_cpu_stall),
    .ld_req(a_ld_req), .ld_we(a_ld_we), .ld_addr(a_ld_addr),
    .ld_wdata(a_ld_wdata), .ld_rdata(a_ld_rdata), .ld_ack(a_ld_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .gnt(a_gnt), .busy(a_busy)
  );

  // Read-only memory for A: data is valid exactly one cycle after mem_en.
  logic        pa_v = 1'b0;
  logic [31:0] pa_d = '0;
  always @(posedge clk) begin
    pa_v <= a_mem_en && !a_mem_we;
    pa_d <= (a_mem_addr == 32'h10) ? 32'hDEAD_BEEF : ~a_mem_addr;
  end
  assign a_mem_rdata = pa_v ? pa_d : (32'hBAD1_0000 ^ 32'(cyc));

  // ---------------- instance B (LAT=3) ----------------
  logic        rq[2];
  logic        wen[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];
  logic [31:0] b_cpu_rdata, b_ld_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_ack, b_cpu_stall, b_ld_ack, b_mem_en, b_mem_we, b_busy;
  logic [1:0]  b_gnt;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT_B)) u_dut_b (
    .clk(clk), .nrst(nrst),
    .cpu_req(rq[0]), .cpu_we(wen[0]), .cpu_addr(ad[0]),
    .cpu_wdata(wd[0]), .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .cpu_stall(b_cpu_stall),
    .ld_req(rq[1]), .ld_we(wen[1]), .ld_addr(ad[1]),
    .ld_wdata(wd[1]), .ld_rdata(b_ld_rdata), .ld_ack(b_ld_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .gnt(b_gnt), .busy(b_busy)
  );

  // Memory for B: 256 words indexed by addr[7:0]; read data valid exactly
  // LAT_B cycles after the mem_en cycle, garbage at every other time.
  logic        mem_init = 1'b1;
  logic [31:0] memb [256];
  logic [2:0]  pb_v;
  logic [31:0] pb_d [3];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) memb[i] <= 32'hA500_0000 | i;
      pb_v <= 3'b000;
    end else begin
      if (b_mem_en && b_mem_we) memb[b_mem_addr[7:0]] <= b_mem_wdata;
      pb_v <= {pb_v[1:0], b_mem_en && !b_mem_we};
    end
    pb_d[0] <= memb[b_mem_addr[7:0]];
    pb_d[1] <= pb_d[0];
    pb_d[2] <= pb_d[1];
  end
  assign b_mem_rdata = pb_v[2] ? pb_d[2] : (32'hBAD0_0000 ^ 32'(cyc));

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [256];
  int          ack_at [2];
  logic [31:0] pend   [2];
  logic        pend_we[2];
  logic [31:0] exp_rd [2];
  int          free_at, acc_at;
  logic        last_ld;
  logic [1:0]  exp_gnt;
  logic [31:0] acc_addr, acc_wd;
  logic        acc_we;

  initial begin
    int n, prev, port, exp_port, w;
    logic [31:0] r;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | i;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wen[p] = 1'b0; ad[p] = '0; wd[p] = '0;
    end

    // ---- reset state ----
    tick();
    mem_init = 1'b0;
    tick();
    chk("rst_a_ctl", {a_mem_en, a_mem_we, a_cpu_ack, a_ld_ack, a_cpu_stall, a_busy, a_gnt}, 0);
    chk("rst_a_data", {a_cpu_rdata, a_ld_rdata}, 0);
    chk("rst_a_mem", {a_mem_addr, a_mem_wdata}, 0);
    chk("rst_b_ctl", {b_mem_en, b_mem_we, b_cpu_ack, b_ld_ack, b_cpu_stall, b_busy, b_gnt}, 0);
    chk("rst_b_data", {b_cpu_rdata, b_ld_rdata}, 0);
    chk("rst_b_mem", {b_mem_addr, b_mem_wdata}, 0);
    nrst = 1'b1;
    tick();

    // ---- A: LAT=1 CPU read of 0x10 ----
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h10;
    #1;
    chk("a_stall_c0", a_cpu_stall, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("a_mem_en", a_mem_en, k == 1);
      chk("a_cpu_ack", a_cpu_ack, k == 3);
      chk("a_stall", a_cpu_stall, k != 3);
      if (k == 3) chk("a_rdata", a_cpu_rdata, 32'hDEAD_BEEF);
    end
    a_cpu_req = 1'b0;
    tick();
    chk("a_idle_busy", {a_busy, a_cpu_ack, a_gnt}, 0);
    chk("a_rdata_hold", a_cpu_rdata, 32'hDEAD_BEEF);

    // ---- B: loader write 0x40 then CPU read 0x40 ----
    rq[1] = 1'b1; wen[1] = 1'b1; ad[1] = 32'h40; wd[1] = 32'h1234_5678;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("w_ld_ack", b_ld_ack, k == 5);
      chk("w_mem_en", b_mem_en, k == 1);
      if (k == 1) chk("w_mem_acc", {b_mem_we, b_mem_addr, b_mem_wdata}, {1'b1, 32'h40, 32'h1234_5678});
    end
    chk("w_ld_rdata", b_ld_rdata, 0);
    rq[1] = 1'b0;
    rq[0] = 1'b1; wen[0] = 1'b0; ad[0] = 32'h40;
    for (int k = 6; k <= 11; k++) begin
      tick();
      chk("rw_cpu_ack", b_cpu_ack, k == 11);
    end
    chk("rw_cpu_rdata", b_cpu_rdata, 32'h1234_5678);
    chk("rw_ld_rdata", b_ld_rdata, 0);
    rq[0] = 1'b0;
    tick();

    // ---- arbitration with both requests held ----
    do_reset();
    rq[0] = 1'b1; wen[0] = 1'b0; ad[0] = 32'h20;
    rq[1] = 1'b1; wen[1] = 1'b0; ad[1] = 32'h30;
    n = 0; prev = cyc;
    for (int k = 1; k <= 4 * (LAT_B + 3); k++) begin
      tick();
      if (b_cpu_ack || b_ld_ack) begin
        port = b_ld_ack ? 1 : 0;
`ifdef MEM_ARB_RR_EN
        exp_port = n % 2;
`else
        exp_port = 0;
`endif
        chk("arb_port", port, exp_port);
        chk("arb_dual_ack", b_cpu_ack & b_ld_ack, 0);
        chk("arb_spacing", cyc - prev, (n == 0) ? LAT_B + 2 : LAT_B + 3);
        if (port == 0) chk("arb_cpu_data", b_cpu_rdata, 32'hA500_0020);
        else           chk("arb_ld_data",  b_ld_rdata,  32'hA500_0030);
        prev = cyc;
        n++;
      end
    end
    chk("arb_count", n, 4);
    rq[0] = 1'b0; rq[1] = 1'b0;
    tick();

    // ---- reset during WAIT of a CPU read ----
    rq[0] = 1'b1; wen[0] = 1'b0; ad[0] = 32'h50;
    tick();
    chk("rw_access", b_mem_en, 1);
    tick();
    chk("rw_wait", {b_busy, b_cpu_ack}, 2'b10);
    #2;
    nrst = 1'b0;
    #1;
    chk("rw_async_ctl", {b_mem_en, b_cpu_ack, b_ld_ack, b_cpu_stall, b_busy, b_gnt}, 0);
    chk("rw_async_data", {b_cpu_rdata, b_ld_rdata, b_mem_we}, 0);
    chk("rw_async_mem", {b_mem_addr, b_mem_wdata}, 0);
    tick();
    chk("rw_held_ack", b_cpu_ack, 0);
    nrst = 1'b1;
    #1;
    chk("rw_first_idle", {b_busy, b_cpu_stall}, 2'b01);
    for (int k = 1; k <= LAT_B + 2; k++) begin
      tick();
      chk("rr_mem_en", b_mem_en, k == 1);
      chk("rr_cpu_ack", b_cpu_ack, k == LAT_B + 2);
    end
    chk("rr_rdata", b_cpu_rdata, 32'hA500_0050);
    rq[0] = 1'b0;
    tick();

    // ---- request dropped during ACCESS ----
    rq[0] = 1'b1; wen[0] = 1'b0; ad[0] = 32'h60;
    tick();
    chk("dr_access", b_mem_en, 1);
    rq[0] = 1'b0;
    #1;
    chk("dr_stall", b_cpu_stall, 0);
    for (int k = 2; k <= LAT_B + 3; k++) begin
      tick();
      chk("dr_ack", b_cpu_ack, k == LAT_B + 2);
      chk("dr_busy", b_busy, k <= LAT_B + 2);
    end
    chk("dr_rdata", b_cpu_rdata, 32'hA500_0060);

    // ---- randomized traffic against the transaction model ----
    do_reset();
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; ack_at[p] = -1; exp_rd[p] = '0; pend[p] = '0; pend_we[p] = 1'b0;
    end
    free_at = cyc; acc_at = -1; last_ld = 1'b1; exp_gnt = 2'b00;
    acc_addr = '0; acc_wd = '0; acc_we = 1'b0;
    repeat (600) begin
      for (int p = 0; p < 2; p++)
        if (cyc == ack_at[p] && !pend_we[p]) exp_rd[p] = pend[p];
      chk("r_cpu_ack", b_cpu_ack, cyc == ack_at[0]);
      chk("r_ld_ack", b_ld_ack, cyc == ack_at[1]);
      chk("r_cpu_rdata", b_cpu_rdata, exp_rd[0]);
      chk("r_ld_rdata", b_ld_rdata, exp_rd[1]);
      chk("r_stall", b_cpu_stall, rq[0] && (cyc != ack_at[0]));
      chk("r_busy", b_busy, cyc < free_at);
      chk("r_gnt", b_gnt, (cyc < free_at) ? exp_gnt : 2'b00);
      chk("r_mem_en", b_mem_en, cyc == acc_at);
      if (cyc == acc_at) begin
        chk("r_mem_addr", {b_mem_we, b_mem_addr}, {acc_we, acc_addr});
        if (acc_we) chk("r_mem_wdata", b_mem_wdata, acc_wd);
      end

      // requesters: new work after ack, occasional mid-flight drop, idle raise
      for (int p = 0; p < 2; p++) begin
        if (cyc == ack_at[p] || (!rq[p] && ack_at[p] < cyc)) begin
          if ((cyc == ack_at[p]) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0)) begin
            r = $urandom;
            rq[p]  = 1'b1;
            wen[p] = 1'($urandom_range(0, 1));
            ad[p]  = {r[31:8], 3'b000, 5'($urandom_range(0, 31))};
            wd[p]  = $urandom;
          end else begin
            rq[p] = 1'b0;
          end
        end else if (rq[p] && ack_at[p] > cyc && $urandom_range(0, 15) == 0) begin
          rq[p] = 1'b0;
        end
      end

      // arbitration happens only when the arbiter is idle this cycle
      if (cyc >= free_at && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) begin
`ifdef MEM_ARB_RR_EN
          w = last_ld ? 0 : 1;
`else
          w = 0;
`endif
        end else begin
          w = rq[1] ? 1 : 0;
        end
        last_ld    = (w == 1);
        exp_gnt    = (w == 1) ? 2'b10 : 2'b01;
        acc_at     = cyc + 1;
        ack_at[w]  = cyc + LAT_B + 2;
        free_at    = cyc + LAT_B + 3;
        acc_addr   = ad[w];
        acc_we     = wen[w];
        acc_wd     = wd[w];
        pend_we[w] = wen[w];
        if (wen[w]) ref_mem[ad[w][7:0]] = wd[w];
        else        pend[w] = ref_mem[ad[w][7:0]];
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
